// File: rtl/poly_addsub_if.sv
// Control and RAM-port bundle for poly_addsub_engine.
// The master modport is the engine side; slave is the controller/RAM side.
interface poly_addsub_if #(
  parameter int unsigned COEFF_W = 12,
  parameter int unsigned LANES   = 8,
  parameter int unsigned ADDR_W  = 8
);
  localparam int unsigned DATA_W = LANES * COEFF_W;

  logic                start;
  logic [1:0]          op;
  logic [ADDR_W-1:0]   r_start_offset_A;
  logic [ADDR_W-1:0]   r_start_offset_B;
  logic [ADDR_W-1:0]   w_data_addr_offset;
  logic [DATA_W-1:0]   r_data;
  logic [ADDR_W-1:0]   r_data_addr;
  logic [ADDR_W-1:0]   w_data_addr;
  logic [DATA_W-1:0]   w_data;
  logic                w_data_en;
  logic                busy;
  logic                done;
  logic                range_err;

  modport master (
    input  start, op, r_start_offset_A, r_start_offset_B, w_data_addr_offset, r_data,
    output r_data_addr, w_data_addr, w_data, w_data_en, busy, done, range_err
  );

  modport slave (
    output start, op, r_start_offset_A, r_start_offset_B, w_data_addr_offset, r_data,
    input  r_data_addr, w_data_addr, w_data, w_data_en, busy, done, range_err
  );
endinterface

// File: rtl/poly_addsub_engine.sv
// Streaming mod-Q polynomial add/sub/reverse-sub/copy over a shared single-read-port RAM.
// Optional input range checking is enabled by defining POLY_ADDSUB_RANGE_CHECK_EN.
module poly_addsub_engine #(
  parameter int unsigned COEFF_W = 12,
  parameter int unsigned LANES   = 8,
  parameter int unsigned WORDS   = 32,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned Q       = 3329
) (
  input logic           clk,
  input logic           rst,
  poly_addsub_if.master bus
);
  localparam int unsigned DATA_W = LANES * COEFF_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_RSUB = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
  localparam logic [COEFF_W:0]  Q_EXT     = (COEFF_W + 1)'(Q);

  logic [1:0]        state_q, state_d;
  logic              phase_q, phase_d;  // 0: A address on the bus, 1: B address
  logic [ADDR_W-1:0] rd_word_q, rd_word_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d;
  logic [ADDR_W-1:0] wr_word_q;
  logic [ADDR_W-1:0] off_a_q, off_b_q, woff_q;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] a_q;
  logic              b_valid_q;
  logic [DATA_W-1:0] w_data_q;
  logic [ADDR_W-1:0] w_addr_q;
  logic              w_en_q, done_q, busy_q;
  logic [DATA_W-1:0] result;
  logic              accept, a_capture;

  assign accept    = (state_q == ST_IDLE) && bus.start;
  assign a_capture = (state_q == ST_RUN) && phase_q;

  function automatic logic [COEFF_W-1:0] lane_op(input logic [1:0] op,
                                                 input logic [COEFF_W-1:0] a,
                                                 input logic [COEFF_W-1:0] b);
    logic [COEFF_W:0] x, y, s, d;
    logic [COEFF_W:0] r;
    x = {1'b0, a};
    y = {1'b0, b};
    s = x + y;
    if (s >= Q_EXT) s = s - Q_EXT;
    r = x;
    case (op)
      OP_ADD:  r = s;
      OP_SUB, OP_RSUB: begin
        d = (op == OP_SUB) ? (x - y) : (y - x);
        // Operands are below 2^COEFF_W, so the top bit flags a negative difference
        if (d[COEFF_W]) d = d + Q_EXT;
        r = d;
      end
      default: r = x;
    endcase
    return r[COEFF_W-1:0];
  endfunction

  always_comb begin
    result = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      result[k*COEFF_W +: COEFF_W] = lane_op(op_q, a_q[k*COEFF_W +: COEFF_W],
                                             bus.r_data[k*COEFF_W +: COEFF_W]);
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    rd_word_d = rd_word_q;
    r_addr_d  = r_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_RUN;
          phase_d   = 1'b0;
          rd_word_d = '0;
          r_addr_d  = bus.r_start_offset_A;
        end
      end
      ST_RUN: begin
        if (!phase_q) begin
          phase_d  = 1'b1;
          r_addr_d = off_b_q + rd_word_q;
        end else if (rd_word_q == LAST_WORD) begin
          state_d = ST_DRAIN;
          phase_d = 1'b0;
        end else begin
          phase_d   = 1'b0;
          rd_word_d = rd_word_q + ONE;
          r_addr_d  = off_a_q + rd_word_q + ONE;
        end
      end
      ST_DRAIN: begin
        if (done_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= 1'b0;
      rd_word_q <= '0;
      r_addr_q  <= '0;
      wr_word_q <= '0;
      off_a_q   <= '0;
      off_b_q   <= '0;
      woff_q    <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_valid_q <= 1'b0;
      w_data_q  <= '0;
      w_addr_q  <= '0;
      w_en_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      rd_word_q <= rd_word_d;
      r_addr_q  <= r_addr_d;
      b_valid_q <= a_capture;
      w_en_q    <= b_valid_q;
      done_q    <= b_valid_q && (wr_word_q == LAST_WORD);
      if (accept) begin
        off_a_q   <= bus.r_start_offset_A;
        off_b_q   <= bus.r_start_offset_B;
        woff_q    <= bus.w_data_addr_offset;
        op_q      <= bus.op;
        wr_word_q <= '0;
        busy_q    <= 1'b1;
      end else if (done_q) begin
        busy_q <= 1'b0;
      end
      if (a_capture) a_q <= bus.r_data;
      // r_data carries the B word in the cycle after the B address
      if (b_valid_q) begin
        w_data_q  <= result;
        w_addr_q  <= woff_q + wr_word_q;
        wr_word_q <= wr_word_q + ONE;
      end
    end
  end

  assign bus.r_data_addr = r_addr_q;
  assign bus.w_data_addr = w_addr_q;
  assign bus.w_data      = w_data_q;
  assign bus.w_data_en   = w_en_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

`ifdef POLY_ADDSUB_RANGE_CHECK_EN
  logic range_err_q;
  logic lane_oor;

  always_comb begin
    lane_oor = 1'b0;
    for (int k = 0; k < int'(LANES); k++) begin
      if ({1'b0, bus.r_data[k*COEFF_W +: COEFF_W]} >= Q_EXT) lane_oor = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      range_err_q <= 1'b0;
    end else if (accept) begin
      range_err_q <= 1'b0;
    end else if ((a_capture || b_valid_q) && lane_oor) begin
      range_err_q <= 1'b1;
    end
  end

  assign bus.range_err = range_err_q;
`else
  assign bus.range_err = 1'b0;
`endif
endmodule

// File: tb/tb_poly_addsub_engine.sv
// Directed bench for poly_addsub_engine with a RAM model and a write scoreboard.
module tb_poly_addsub_engine;
  localparam int unsigned COEFF_W = 12;
  localparam int unsigned LANES   = 8;
  localparam int unsigned WORDS   = 32;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned Q       = 3329;
  localparam int unsigned DATA_W  = LANES * COEFF_W;
  localparam int          QI      = 3329;
`ifdef POLY_ADDSUB_RANGE_CHECK_EN
  localparam bit RCHK = 1'b1;
`else
  localparam bit RCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  poly_addsub_if #(.COEFF_W(COEFF_W), .LANES(LANES), .ADDR_W(ADDR_W)) bus ();

  poly_addsub_engine #(
    .COEFF_W(COEFF_W), .LANES(LANES), .WORDS(WORDS), .ADDR_W(ADDR_W), .Q(Q)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [256];
  always @(posedge clk) begin
    bus.r_data <= mem[bus.r_data_addr];
    if (bus.w_data_en) mem[bus.w_data_addr] <= bus.w_data;
  end

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    bit                chk;
  } wr_t;
  wr_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pack(input int l0, input int l1, input int l2,
                                             input int l3, input int l4, input int l5,
                                             input int l6, input int l7);
    logic [DATA_W-1:0] w;
    w = {COEFF_W'(l7), COEFF_W'(l6), COEFF_W'(l5), COEFF_W'(l4),
         COEFF_W'(l3), COEFF_W'(l2), COEFF_W'(l1), COEFF_W'(l0)};
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] model(input int op, input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    int x, y, z;
    r = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      x = int'(a[k*COEFF_W +: COEFF_W]);
      y = int'(b[k*COEFF_W +: COEFF_W]);
      case (op)
        0:       z = (x + y) % QI;
        1:       z = (x - y + QI) % QI;
        2:       z = (y - x + QI) % QI;
        default: z = x;
      endcase
      r[k*COEFF_W +: COEFF_W] = COEFF_W'(z);
    end
    return r;
  endfunction

  function automatic bit all_in(input logic [DATA_W-1:0] w);
    bit ok;
    ok = 1'b1;
    for (int k = 0; k < int'(LANES); k++) begin
      if (int'(w[k*COEFF_W +: COEFF_W]) >= QI) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [127:0] outs();
    return 128'({bus.r_data_addr, bus.w_data_addr, bus.w_data, bus.w_data_en, bus.busy,
                 bus.done, bus.range_err});
  endfunction

  // repulse/abort_at: relative cycle for a stray start / a reset, -1 for none
  task automatic run(input int op, input int oa, input int ob, input int ow,
                     input int repulse, input int abort_at, input bit exp_rerr);
    logic [DATA_W-1:0] snap [256];
    logic [ADDR_W-1:0] ea;
    wr_t e;
    int rel, first_wr, done_cyc, nwr;
    bit aborted, rerr_done;
    snap = mem;
    for (int i = 0; i < int'(WORDS); i++) begin
      e.addr = ADDR_W'(ow + i);
      e.data = model(op, snap[ADDR_W'(oa + i)], snap[ADDR_W'(ob + i)]);
      e.chk  = all_in(snap[ADDR_W'(oa + i)]) && all_in(snap[ADDR_W'(ob + i)]);
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 2'(op);
    bus.r_start_offset_A = ADDR_W'(oa);
    bus.r_start_offset_B = ADDR_W'(ob);
    bus.w_data_addr_offset = ADDR_W'(ow);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op = ~bus.op;
    bus.r_start_offset_A = 8'hA5;
    bus.r_start_offset_B = 8'h5A;
    bus.w_data_addr_offset = 8'h33;
    check("busy_cycle0", 128'(bus.busy), 128'(1));
    check("range_err_cleared", 128'(bus.range_err), 128'(0));
    rel = 0; first_wr = -1; done_cyc = -1; nwr = 0; aborted = 1'b0; rerr_done = 1'b0;
    while (done_cyc < 0 && !aborted && rel < 4 * int'(WORDS) + 10) begin
      if (rel == abort_at) begin
        rst = 1'b1;
        #1;
        check("abort_outputs_zero", outs(), 128'(0));
        aborted = 1'b1;
        sb.delete();
      end else begin
        if (rel < 2 * int'(WORDS)) begin
          ea = ADDR_W'(((rel % 2) != 0 ? ob : oa) + rel / 2);
          check("r_data_addr", 128'(bus.r_data_addr), 128'(ea));
        end
        if (bus.w_data_en) begin
          if (first_wr < 0) first_wr = rel;
          nwr++;
          if (sb.size() == 0) begin
            check("unexpected_write", 128'(1), 128'(0));
          end else begin
            e = sb.pop_front();
            check("w_data_addr", 128'(bus.w_data_addr), 128'(e.addr));
            if (e.chk) check("w_data", 128'(bus.w_data), 128'(e.data));
          end
        end
        bus.start = (rel == repulse);
        if (bus.done) begin
          done_cyc = rel;
          rerr_done = bus.range_err;
          bus.start = 1'b1;  // start coincident with done must be ignored
        end
        @(negedge clk);
        rel++;
      end
    end
    if (aborted) begin
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
        check("after_abort_idle", 128'({bus.done, bus.w_data_en, bus.busy}), 128'(0));
        @(negedge clk);
      end
    end else begin
      bus.start = 1'b0;
      check("done_cycle", 128'(done_cyc), 128'(2 * WORDS + 1));
      check("first_write_cycle", 128'(first_wr), 128'(3));
      check("write_count", 128'(nwr), 128'(WORDS));
      check("scoreboard_empty", 128'(sb.size()), 128'(0));
      check("range_err_at_done", 128'(rerr_done), 128'(exp_rerr & RCHK));
      check("busy_after_done", 128'(bus.busy), 128'(0));
      check("range_err_held", 128'(bus.range_err), 128'(exp_rerr & RCHK));
      sb.delete();
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op = '0;
    bus.r_start_offset_A = '0;
    bus.r_start_offset_B = '0;
    bus.w_data_addr_offset = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = pack($urandom_range(0, QI - 1), $urandom_range(0, QI - 1),
                    $urandom_range(0, QI - 1), $urandom_range(0, QI - 1),
                    $urandom_range(0, QI - 1), $urandom_range(0, QI - 1),
                    $urandom_range(0, QI - 1), $urandom_range(0, QI - 1));
    end
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    mem[0]   = pack(0, 1, 128, 129, 64, 65, 192, 193);
    mem[100] = pack(3328, 3328, 3201, 3200, 3300, 1, 0, 3136);
    run(0, 0, 100, 200, -1, -1, 1'b0);
    check("plan_add_word0", 128'(mem[200]), 128'(pack(3328, 0, 0, 0, 35, 66, 192, 0)));

    mem[32] = pack(5, 5, 5, 5, 5, 5, 5, 5);
    mem[64] = pack(7, 7, 7, 7, 7, 7, 7, 7);
    run(1, 32, 64, 140, -1, -1, 1'b0);
    check("sub_5_7", 128'(mem[140]), 128'(pack(3327, 3327, 3327, 3327, 3327, 3327, 3327, 3327)));
    run(1, 64, 32, 140, -1, -1, 1'b0);
    check("sub_7_5", 128'(mem[140]), 128'(pack(2, 2, 2, 2, 2, 2, 2, 2)));
    run(2, 32, 64, 140, -1, -1, 1'b0);
    check("rsub_5_7", 128'(mem[140]), 128'(pack(2, 2, 2, 2, 2, 2, 2, 2)));

    run(3, 0, 180, 64, -1, -1, 1'b0);                // copy A to 64..95
    run(0, 240, 120, 230, -1, -1, 1'b0);             // read and write addresses wrap
    run(1, 0, 100, 0, -1, -1, 1'b0);                 // in place
    run(0, 10, 50, 150, 10, -1, 1'b0);               // stray start at cycle 10
    run(0, 0, 100, 200, -1, 20, 1'b0);               // reset at cycle 20
    run(2, 0, 100, 200, -1, -1, 1'b0);               // fresh run after abort

    mem[105][3*COEFF_W +: COEFF_W] = 12'd3329;
    run(0, 0, 100, 200, -1, -1, 1'b1);
    run(3, 0, 180, 64, -1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
